// File: rtl/layer_output_deserializer.sv
// Assembles a stream of dataWidth-bit words into numWords-wide parallel frames.
// Two-deep: an assembly register feeds an output register, so collection can overlap delivery.
module layer_output_deserializer #(
    parameter int numWords = 16,
    parameter int dataWidth = 16,
    localparam int cntWidth = $clog2(numWords),
    localparam int frameWidth = dataWidth * numWords
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [dataWidth-1:0]  serialIn,
    input  logic                  serialValid,
    input  logic                  serialLast,
    output logic                  serialReady,
    output logic [frameWidth-1:0] parallelOut,
    output logic                  parallelValid,
    input  logic                  parallelReady,
    output logic                  frameError
);

    typedef enum logic {COLLECT, HOLD} stateE;

    stateE                 state;
    stateE                 stateNext;
    logic [cntWidth-1:0]   wordIdx;
    logic [frameWidth-1:0] asmReg;
    logic [frameWidth-1:0] outReg;
    logic [frameWidth-1:0] merged;
    logic [frameWidth-1:0] loadData;
    logic                  pValid;
    logic                  errReg;
    logic                  started;
    logic                  accept;
    logic                  lastIdx;
    logic                  outFree;
    logic                  load;

    assign accept  = serialValid && serialReady;
    assign lastIdx = (wordIdx == cntWidth'(numWords - 1));
    assign outFree = !pValid || parallelReady;

    // Current word merged into its slot so a completing frame can bypass assembly.
    always_comb begin
        merged = asmReg;
        merged[wordIdx*dataWidth +: dataWidth] = serialIn;
    end

    assign load = (accept && lastIdx && outFree)
               || (state == HOLD && outFree);
    assign loadData = (state == HOLD) ? asmReg : merged;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= COLLECT;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            COLLECT: begin
                if (accept && lastIdx && !outFree) begin
                    stateNext = HOLD;
                end
            end
            HOLD: begin
                if (outFree) begin
                    stateNext = COLLECT;
                end
            end
            default: stateNext = COLLECT;
        endcase
    end

    always_comb begin
        serialReady   = started && (state == COLLECT);
        parallelOut   = outReg;
        parallelValid = pValid;
        frameError    = errReg;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            started <= 1'b0;
            wordIdx <= '0;
            asmReg  <= '0;
            outReg  <= '0;
            pValid  <= 1'b0;
            errReg  <= 1'b0;
        end else begin
            started <= 1'b1;
            errReg  <= 1'b0;
            if (accept) begin
                asmReg <= merged;
                if (lastIdx) begin
                    wordIdx <= '0;
                    errReg  <= !serialLast;
                end else if (serialLast) begin
                    // Early last: drop the partial frame and restart at slot 0.
                    wordIdx <= '0;
                    errReg  <= 1'b1;
                end else begin
                    wordIdx <= wordIdx + cntWidth'(1);
                end
            end
            if (load) begin
                outReg <= loadData;
                pValid <= 1'b1;
            end else if (pValid && parallelReady) begin
                pValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_layer_output_deserializer.sv
// Bench for layer_output_deserializer: directed scenarios plus random traffic
// checked against a frame-queue reference model.
module tb_layer_output_deserializer;

    localparam int NW = 4;
    localparam int DW = 16;
    localparam int FW = NW * DW;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [DW-1:0] serialIn = '0;
    logic          serialValid = 1'b0;
    logic          serialLast = 1'b0;
    logic          serialReady;
    logic [FW-1:0] parallelOut;
    logic          parallelValid;
    logic          parallelReady = 1'b0;
    logic          frameError;

    layer_output_deserializer #(.numWords(NW), .dataWidth(DW)) dut (
        .clk(clk),
        .reset(reset),
        .serialIn(serialIn),
        .serialValid(serialValid),
        .serialLast(serialLast),
        .serialReady(serialReady),
        .parallelOut(parallelOut),
        .parallelValid(parallelValid),
        .parallelReady(parallelReady),
        .frameError(frameError)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total = 0;

    // Reference model: words of the frame in progress, frames awaiting delivery.
    logic [DW-1:0] wbuf[$];
    logic [FW-1:0] pend[$];
    logic          started = 1'b0;
    logic          expErr = 1'b0;
    logic          lastAcc = 1'b0;

    task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic modelReady();
        return started && (pend.size() < 2);
    endfunction

    task automatic modelUpdate(input logic v, input logic [DW-1:0] d, input logic l, input logic pr);
        logic acc;
        logic [FW-1:0] f;
        acc = v && modelReady();
        lastAcc = acc;
        expErr = 1'b0;
        if (pend.size() > 0 && pr) void'(pend.pop_front());
        if (acc) begin
            wbuf.push_back(d);
            if (wbuf.size() == NW) begin
                f = '0;
                for (int k = 0; k < NW; k++) f[k*DW +: DW] = wbuf[k];
                pend.push_back(f);
                expErr = !l;
                wbuf.delete();
            end else if (l) begin
                expErr = 1'b1;
                wbuf.delete();
            end
        end
        started = 1'b1;
    endtask

    task automatic checkAll();
        chk("serialReady", FW'(serialReady), FW'(modelReady()));
        chk("parallelValid", FW'(parallelValid), FW'(pend.size() > 0));
        chk("frameError", FW'(frameError), FW'(expErr));
        if (pend.size() > 0) chk("parallelOut", parallelOut, pend[0]);
    endtask

    task automatic step(input logic v, input logic [DW-1:0] d, input logic l, input logic pr);
        serialValid = v;
        serialIn = d;
        serialLast = l;
        parallelReady = pr;
        @(posedge clk);
        modelUpdate(v, d, l, pr);
        @(negedge clk);
        checkAll();
    endtask

    // Offer one word until the model says it was taken, with a bounded wait.
    task automatic sendWord(input logic [DW-1:0] d, input logic l, input logic pr);
        int n;
        n = 0;
        do begin
            step(1'b1, d, l, pr);
            n++;
        end while (!lastAcc && n < 20);
        if (!lastAcc) begin
            total++;
            $error("FAIL sendWord_timeout observed=%0d expected=<20", n);
        end
    endtask

    task automatic sendFrame(input logic [DW-1:0] base, input logic pr);
        for (int k = 0; k < NW; k++) sendWord(base + DW'(k), k == NW - 1, pr);
    endtask

    task automatic idle(input int n, input logic pr);
        for (int k = 0; k < n; k++) step(1'b0, '0, 1'b0, pr);
    endtask

    task automatic doReset();
        reset = 1'b0;
        serialValid = 1'b0;
        serialLast = 1'b0;
        #1;
        chk("rst_serialReady", FW'(serialReady), '0);
        chk("rst_parallelValid", FW'(parallelValid), '0);
        chk("rst_parallelOut", parallelOut, '0);
        chk("rst_frameError", FW'(frameError), '0);
        wbuf.delete();
        pend.delete();
        started = 1'b0;
        expErr = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        logic [FW-1:0] ex;
        logic v, l, pr;
        @(negedge clk);
        doReset();

        // Reset mid-frame after two words, then a clean frame must start in slot 0.
        sendWord(16'h00AA, 1'b0, 1'b1);
        sendWord(16'h00BB, 1'b0, 1'b1);
        @(negedge clk);
        doReset();
        sendFrame(16'h0001, 1'b1);
        ex = 64'h0004_0003_0002_0001;
        chk("frame1_literal", parallelOut, ex);
        chk("frame1_valid", FW'(parallelValid), 1);
        idle(2, 1'b1);

        // Backpressure: A held, B parks in assembly and stalls input.
        sendFrame(16'h1111, 1'b0);
        sendFrame(16'h2221, 1'b0);
        chk("hold_ready_low", FW'(serialReady), '0);
        idle(3, 1'b0);
        ex = 64'h1114_1113_1112_1111;
        chk("hold_A_stable", parallelOut, ex);
        step(1'b0, '0, 1'b0, 1'b1);
        ex = 64'h2224_2223_2222_2221;
        chk("hold_B_out", parallelOut, ex);
        chk("hold_ready_back", FW'(serialReady), 1);
        idle(2, 1'b1);

        // Back-to-back frames with a free consumer.
        for (int f = 0; f < 3; f++) sendFrame(16'h3000 + DW'(f * 16), 1'b1);
        idle(2, 1'b1);

        // Early last aborts, following frame is intact.
        sendWord(16'hAAAA, 1'b0, 1'b1);
        sendWord(16'hBBBB, 1'b1, 1'b1);
        chk("early_err", FW'(frameError), 1);
        chk("early_noout", FW'(parallelValid), '0);
        sendFrame(16'h0005, 1'b1);
        ex = 64'h0008_0007_0006_0005;
        chk("after_abort", parallelOut, ex);
        idle(2, 1'b1);

        // Missing last: frame still delivered, error flagged with it.
        for (int k = 0; k < NW; k++) sendWord(16'h0900 + DW'(k), 1'b0, 1'b1);
        chk("nolast_err", FW'(frameError), 1);
        ex = 64'h0903_0902_0901_0900;
        chk("nolast_out", parallelOut, ex);
        idle(2, 1'b1);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            v = ($urandom % 4) != 0;
            pr = ($urandom % 3) != 0;
            l = (wbuf.size() == NW - 1) ^ (($urandom % 16) == 0);
            step(v, DW'($urandom), l, pr);
        end
        idle(4, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
